// File: rtl/reg_select_pkg.sv
// Shared constants and index helpers for the register-select stage.
package reg_select_pkg;

    // Select code meaning "no register".
    localparam int unsigned SEL_NONE = 0;

    // Widest register file the helpers support.
    localparam int unsigned MAX_REGS = 32;

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned num_regs);
        return idx < num_regs;
    endfunction

    // Mux-select code: index+1 for a real register, SEL_NONE otherwise.
    function automatic int unsigned idx_to_sel(input int unsigned idx, input int unsigned num_regs);
        return idx_in_range(idx, num_regs) ? idx + 1 : SEL_NONE;
    endfunction

    // One-hot vector with bit idx set; all zero when idx is out of range.
    function automatic logic [MAX_REGS-1:0] idx_to_onehot(input int unsigned idx, input int unsigned num_regs);
        logic [MAX_REGS-1:0] oh;
        oh = '0;
        if (idx_in_range(idx, num_regs)) begin
            oh = 32'(1) << idx;
        end
        return oh;
    endfunction

endpackage

// File: rtl/reg_select_stage_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// write-back or when the entry carrying the write is flushed.
module reg_scoreboard
    import reg_select_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    localparam int unsigned IDX_W = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [IDX_W-1:0]    set_idx,
    input  logic [NUM_REGS-1:0] wb_vec,
    input  logic [NUM_REGS-1:0] clr_vec,
    output logic [NUM_REGS-1:0] pending,
    output logic [NUM_REGS-1:0] pending_eff
);

    logic [NUM_REGS-1:0] set_vec;

    // Decode the set request and expose the write-back bypassed view.
    always_comb begin
        set_vec     = '0;
        if (set_en) begin
            set_vec = NUM_REGS'(idx_to_onehot(32'(set_idx), NUM_REGS));
        end
        pending_eff = pending & ~wb_vec;
    end

    // Scoreboard state; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

endmodule

// File: rtl/reg_select_stage.sv
// Register-address decode stage: registers select codes and the write-enable
// vector, and stalls instructions that touch a register with a pending write.
module reg_select_stage
    import reg_select_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    localparam int unsigned IDX_W = $clog2(NUM_REGS),
    localparam int unsigned SEL_W = $clog2(NUM_REGS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IDX_W-1:0]    rsrc_idx,
    input  logic [IDX_W-1:0]    rdst_idx,
    input  logic                use_rsrc,
    input  logic                wr_req,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SEL_W-1:0]    rsrc_sel,
    output logic [SEL_W-1:0]    rdst_sel,
    output logic [NUM_REGS-1:0] rdst_wen,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_idx,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pending,
    output logic                hazard
);

    logic [NUM_REGS-1:0] src_oh;
    logic [NUM_REGS-1:0] dst_oh;
    logic [NUM_REGS-1:0] wb_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] pending_eff;
    logic [SEL_W-1:0]    src_sel_d;
    logic [SEL_W-1:0]    dst_sel_d;
    logic [NUM_REGS-1:0] wen_d;
    logic                dst_ok;
    logic                accept;
    logic                set_en;

    // Decode indices, evaluate the hazard and the upstream handshake.
    always_comb begin
        src_oh    = NUM_REGS'(idx_to_onehot(32'(rsrc_idx), NUM_REGS));
        dst_oh    = NUM_REGS'(idx_to_onehot(32'(rdst_idx), NUM_REGS));
        dst_ok    = idx_in_range(32'(rdst_idx), NUM_REGS);
        src_sel_d = use_rsrc ? SEL_W'(idx_to_sel(32'(rsrc_idx), NUM_REGS)) : SEL_W'(SEL_NONE);
        dst_sel_d = SEL_W'(idx_to_sel(32'(rdst_idx), NUM_REGS));
        wen_d     = wr_req ? dst_oh : '0;

        wb_vec    = wb_valid ? NUM_REGS'(idx_to_onehot(32'(wb_idx), NUM_REGS)) : '0;
        // A flushed entry's write will never happen, so release its register.
        clr_vec   = wb_vec | ((flush && out_valid) ? rdst_wen : '0);

        hazard    = in_valid & ((use_rsrc & (|(pending_eff & src_oh))) | (|(pending_eff & dst_oh)));
        in_ready  = !reset && !flush && !hazard && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        set_en    = accept && wr_req && dst_ok;
    end

    reg_scoreboard #(
        .NUM_REGS(NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (set_en),
        .set_idx    (rdst_idx),
        .wb_vec     (wb_vec),
        .clr_vec    (clr_vec),
        .pending    (pending),
        .pending_eff(pending_eff)
    );

    // Output register: load on accept, drop on consume or flush, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            rsrc_sel  <= '0;
            rdst_sel  <= '0;
            rdst_wen  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            rsrc_sel  <= src_sel_d;
            rdst_sel  <= dst_sel_d;
            rdst_wen  <= wen_d;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
